dconv_ctrl: RTL and testbench

Sequencer for the depthwise convolution datapath (`dconv`). On a start pulse it loads per-channel weight/bias/shift words from a parameter memory and holds them on the `dconv` parameter buses. It then streams one feature-map tile pixel by pixel from the feature buffer into `dconv` and writes every valid `dconv` output to the output buffer. It sits between the layer scheduler (start/done) and the `dconv` instance plus its three memories.

---
 rtl/dconv_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dconv_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dconv_ctrl.sv
// dconv_ctrl: loads per-channel parameters, streams one tile into dconv,
// and writes every valid dconv output to the output buffer.
// Ports: clk/rst (sync, active high), start/busy/done/err handshake,
//   param_rd_* (parameter memory), fmap_rd_* (feature buffer),
//   conv_* (dconv control, data and parameter buses), out_wr_* (output buffer).
module dconv_ctrl #(
    parameter int N             = 8,
    parameter int INPUT_CHANNEL = 3,
    parameter int INPUT_SIZE    = 6,
    parameter int KERNEL_SIZE   = 3,
    parameter int STRIDE        = 1,
    parameter int PADDING       = 0,
    parameter int DILATION      = 1,
    parameter int TIMEOUT       = 1024,
    localparam int KKN  = KERNEL_SIZE * KERNEL_SIZE * N,
    localparam int PW   = KKN + 37,
    localparam int OSZ  = (INPUT_SIZE + 2 * PADDING - DILATION * (KERNEL_SIZE - 1) - 1) / STRIDE + 1,
    localparam int NPIX = INPUT_SIZE * INPUT_SIZE,
    localparam int NOUT = OSZ * OSZ,
    localparam int CAW  = (INPUT_CHANNEL > 1) ? $clog2(INPUT_CHANNEL) : 1,
    localparam int FAW  = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int OAW  = (NOUT > 1) ? $clog2(NOUT) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            param_rd_en,
    output logic [CAW-1:0]                  param_rd_addr,
    input  logic [PW-1:0]                   param_rd_data,
    output logic                            fmap_rd_en,
    output logic [FAW-1:0]                  fmap_rd_addr,
    input  logic [INPUT_CHANNEL*N-1:0]      fmap_rd_data,
    output logic                            conv_rst_n,
    output logic                            conv_input_vld,
    output logic [INPUT_CHANNEL*N-1:0]      conv_input_din,
    output logic [INPUT_CHANNEL*KKN-1:0]    conv_weight_din,
    output logic [INPUT_CHANNEL*32-1:0]     conv_bias_din,
    output logic [INPUT_CHANNEL*5-1:0]      conv_shift_din,
    input  logic [INPUT_CHANNEL*N-1:0]      conv_dout,
    input  logic                            conv_dout_vld,
    input  logic                            conv_dout_end,
    output logic                            out_wr_en,
    output logic [OAW-1:0]                  out_wr_addr,
    output logic [INPUT_CHANNEL*N-1:0]      out_wr_data
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_LOAD_WAIT = 3'd2;
    localparam logic [2:0] S_STREAM    = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;
    localparam logic [2:0] S_FIN       = 3'd5;

    logic [2:0]                 state_q, state_d;
    logic [CAW-1:0]             ch_q, ch_d;
    logic [FAW-1:0]             pix_q, pix_d;
    // one bit wider than the address so a full tile does not wrap to 0
    logic [OAW:0]               wcnt_q, wcnt_d;
    logic [TW-1:0]              tcnt_q, tcnt_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       vld_q;
    logic                       cap_vld_q;
    logic [CAW-1:0]             cap_ch_q;
    logic [INPUT_CHANNEL*KKN-1:0] wgt_q;
    logic [INPUT_CHANNEL*32-1:0]  bias_q;
    logic [INPUT_CHANNEL*5-1:0]   shift_q;

    logic in_load, in_flow;

    assign in_load = (state_q == S_LOAD) || (state_q == S_LOAD_WAIT);
    assign in_flow = (state_q == S_STREAM) || (state_q == S_DRAIN);

    assign busy          = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done          = done_q;
    assign err           = err_q;
    assign param_rd_en   = (state_q == S_LOAD);
    assign param_rd_addr = ch_q;
    assign fmap_rd_en    = (state_q == S_STREAM);
    assign fmap_rd_addr  = pix_q;
    assign conv_rst_n    = !in_load;
    assign conv_input_vld  = vld_q;
    assign conv_input_din  = fmap_rd_data;
    assign conv_weight_din = wgt_q;
    assign conv_bias_din   = bias_q;
    assign conv_shift_din  = shift_q;
    assign out_wr_en     = conv_dout_vld && in_flow;
    assign out_wr_data   = conv_dout;
    assign out_wr_addr   = wcnt_q[OAW-1:0];

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (out_wr_en) begin
            wcnt_d = wcnt_q + (OAW+1)'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ch_d    = '0;
                end
            end
            S_LOAD: begin
                wcnt_d = '0;
                if (ch_q == CAW'(INPUT_CHANNEL - 1)) begin
                    state_d = S_LOAD_WAIT;
                    ch_d    = '0;
                end else begin
                    ch_d = ch_q + CAW'(1);
                end
            end
            S_LOAD_WAIT: begin
                state_d = S_STREAM;
                pix_d   = '0;
            end
            S_STREAM: begin
                if (pix_q == FAW'(NPIX - 1)) begin
                    state_d = S_DRAIN;
                    pix_d   = '0;
                    tcnt_d  = '0;
                end else begin
                    pix_d = pix_q + FAW'(1);
                end
            end
            S_DRAIN: begin
                // wcnt_d already includes a write landing with the end flag
                if (conv_dout_end) begin
                    state_d = S_FIN;
                    if (wcnt_d == (OAW+1)'(NOUT)) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            pix_q     <= '0;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
            cap_vld_q <= 1'b0;
            cap_ch_q  <= '0;
            wgt_q     <= '0;
            bias_q    <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            pix_q     <= pix_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            vld_q     <= fmap_rd_en;
            cap_vld_q <= param_rd_en;
            cap_ch_q  <= ch_q;
            // read data trails its address by one cycle
            if (cap_vld_q) begin
                wgt_q[int'(cap_ch_q)*KKN +: KKN] <= param_rd_data[KKN-1:0];
                bias_q[int'(cap_ch_q)*32 +: 32]  <= param_rd_data[KKN +: 32];
                shift_q[int'(cap_ch_q)*5 +: 5]   <= param_rd_data[KKN+32 +: 5];
            end
        end
    end

endmodule

// File: tb/tb_dconv_ctrl.sv
// tb_dconv_ctrl: self-checking bench for dconv_ctrl with parameter/feature
// memory models and a behavioural dconv stub.
module tb_dconv_ctrl;

    localparam int N    = 8;
    localparam int IC   = 3;
    localparam int KKN  = 72;
    localparam int PW   = KKN + 37;
    localparam int NPIX = 36;
    localparam int NOUT = 16;
    localparam int TO   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, err;
    logic param_rd_en;
    logic [1:0] param_rd_addr;
    logic [PW-1:0] param_rd_data = '0;
    logic fmap_rd_en;
    logic [5:0] fmap_rd_addr;
    logic [IC*N-1:0] fmap_rd_data = '0;
    logic conv_rst_n, conv_input_vld;
    logic [IC*N-1:0] conv_input_din;
    logic [IC*KKN-1:0] conv_weight_din;
    logic [IC*32-1:0] conv_bias_din;
    logic [IC*5-1:0] conv_shift_din;
    logic [IC*N-1:0] conv_dout = '0;
    logic conv_dout_vld;
    logic conv_dout_end = 1'b0;
    logic out_wr_en;
    logic [3:0] out_wr_addr;
    logic [IC*N-1:0] out_wr_data;

    dconv_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .err(err),
        .param_rd_en(param_rd_en), .param_rd_addr(param_rd_addr),
        .param_rd_data(param_rd_data),
        .fmap_rd_en(fmap_rd_en), .fmap_rd_addr(fmap_rd_addr),
        .fmap_rd_data(fmap_rd_data),
        .conv_rst_n(conv_rst_n), .conv_input_vld(conv_input_vld),
        .conv_input_din(conv_input_din),
        .conv_weight_din(conv_weight_din), .conv_bias_din(conv_bias_din),
        .conv_shift_din(conv_shift_din),
        .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld),
        .conv_dout_end(conv_dout_end),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
        .out_wr_data(out_wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pat(input int e);
        logic [7:0] b;
        b = 8'(e);
        return {b, b + 8'h40, b + 8'h80};
    endfunction

    // memories: one-cycle read latency
    logic [PW-1:0] pmem [IC];
    always @(posedge clk) begin
        if (param_rd_en) param_rd_data <= pmem[param_rd_addr];
        if (fmap_rd_en) fmap_rd_data <= {3{2'b00, fmap_rd_addr}};
    end

    // dconv stub: after the last input pixel emit stub_nvld outputs, then end
    int stub_nvld = NOUT;
    bit stub_end = 1'b1;
    int in_cnt = 0;
    int emitted = 0;
    bit emitting = 1'b0;
    logic stub_vld = 1'b0;
    logic extra_vld = 1'b0;
    assign conv_dout_vld = stub_vld | extra_vld;

    always @(posedge clk) begin
        stub_vld <= 1'b0;
        conv_dout_end <= 1'b0;
        if (rst || !conv_rst_n) begin
            in_cnt <= 0;
            emitting <= 1'b0;
            emitted <= 0;
        end else begin
            if (conv_input_vld) begin
                in_cnt <= in_cnt + 1;
                if (in_cnt == NPIX - 1) begin
                    emitting <= 1'b1;
                    emitted <= 0;
                end
            end
            if (emitting) begin
                if (emitted < stub_nvld) begin
                    stub_vld <= 1'b1;
                    conv_dout <= pat(emitted);
                    emitted <= emitted + 1;
                end else begin
                    conv_dout_end <= stub_end;
                    emitting <= 1'b0;
                end
            end
        end
    end

    // output-side monitor
    logic [3:0] wa [$];
    logic [23:0] wd [$];
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_wr_en) begin
                wa.push_back(out_wr_addr);
                wd.push_back(out_wr_data);
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (done && err) both_cnt++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_end(input int budget);
        int t;
        t = 0;
        while (!(done || err) && t < budget) begin
            tick();
            t++;
        end
        check("end_within_budget", 128'(done || err), 128'(1));
    endtask

    task automatic check_tile(input int n0, input int nexp);
        check("write_count", 128'(wa.size() - n0), 128'(nexp));
        for (int k = 0; k < nexp; k++) begin
            if (n0 + k < wa.size()) begin
                check($sformatf("wr_addr[%0d]", k), 128'(wa[n0+k]), 128'(k[3:0]));
                check($sformatf("wr_data[%0d]", k), 128'(wd[n0+k]), 128'(pat(k)));
            end
        end
    endtask

    typedef struct {
        int         cyc;
        logic       start;
        logic       p_en;
        logic [1:0] p_addr;
        logic       f_en;
        logic [5:0] f_addr;
        logic       vld;
        logic       rst_n;
        logic       busy;
        logic [23:0] din;
    } vec_t;

    initial begin
        vec_t tbl [12];
        logic [KKN-1:0] w;
        int c0, c1, n0, d0, e0;

        tbl[0]  = '{0,  1, 0, 0, 0, 0,  0, 1, 0, 24'h000000};
        tbl[1]  = '{1,  0, 1, 0, 0, 0,  0, 0, 1, 24'h000000};
        tbl[2]  = '{2,  1, 1, 1, 0, 0,  0, 0, 1, 24'h000000};
        tbl[3]  = '{3,  0, 1, 2, 0, 0,  0, 0, 1, 24'h000000};
        tbl[4]  = '{4,  0, 0, 0, 0, 0,  0, 0, 1, 24'h000000};
        tbl[5]  = '{5,  0, 0, 0, 1, 0,  0, 1, 1, 24'h000000};
        tbl[6]  = '{6,  0, 0, 0, 1, 1,  1, 1, 1, 24'h000000};
        tbl[7]  = '{7,  0, 0, 0, 1, 2,  1, 1, 1, 24'h010101};
        tbl[8]  = '{20, 1, 0, 0, 1, 15, 1, 1, 1, 24'h0e0e0e};
        tbl[9]  = '{40, 0, 0, 0, 1, 35, 1, 1, 1, 24'h222222};
        tbl[10] = '{41, 0, 0, 0, 0, 0,  1, 1, 1, 24'h232323};
        tbl[11] = '{42, 0, 0, 0, 0, 0,  0, 1, 1, 24'h000000};

        for (int j = 0; j < 9; j++) w[j*8 +: 8] = 8'(j + 1);
        pmem[0] = {5'd3, 32'hAAAA0001, {9{8'h11}}};
        pmem[1] = {5'd5, 32'h00000100, w};
        pmem[2] = {5'd31, 32'hFFFFFFFF, {9{8'hC3}}};

        // reset values
        repeat (3) tick();
        check("rst_busy", 128'(busy), 0);
        check("rst_done_err", 128'({done, err}), 0);
        check("rst_enables", 128'({param_rd_en, fmap_rd_en, conv_input_vld, out_wr_en}), 0);
        check("rst_conv_rst_n", 128'(conv_rst_n), 1);
        check("rst_addrs", 128'({param_rd_addr, fmap_rd_addr, out_wr_addr}), 0);
        rst = 1'b0;
        tick();

        // dconv output in IDLE is not written
        extra_vld = 1'b1;
        #1;
        check("idle_vld_ignored", 128'(out_wr_en), 0);
        tick();
        extra_vld = 1'b0;
        check("idle_no_write", 128'(wa.size()), 0);

        // main tile, with stray starts in LOAD and STREAM
        n0 = wa.size();
        d0 = done_cnt;
        e0 = err_cnt;
        c0 = cyc;
        foreach (tbl[i]) begin
            while (cyc - c0 < tbl[i].cyc) begin
                tick();
                start = 1'b0;
            end
            check($sformatf("c%0d_param_en", tbl[i].cyc), 128'(param_rd_en), 128'(tbl[i].p_en));
            check($sformatf("c%0d_param_addr", tbl[i].cyc), 128'(param_rd_addr), 128'(tbl[i].p_addr));
            check($sformatf("c%0d_fmap_en", tbl[i].cyc), 128'(fmap_rd_en), 128'(tbl[i].f_en));
            check($sformatf("c%0d_fmap_addr", tbl[i].cyc), 128'(fmap_rd_addr), 128'(tbl[i].f_addr));
            check($sformatf("c%0d_in_vld", tbl[i].cyc), 128'(conv_input_vld), 128'(tbl[i].vld));
            check($sformatf("c%0d_conv_rst_n", tbl[i].cyc), 128'(conv_rst_n), 128'(tbl[i].rst_n));
            check($sformatf("c%0d_busy", tbl[i].cyc), 128'(busy), 128'(tbl[i].busy));
            if (tbl[i].vld)
                check($sformatf("c%0d_in_din", tbl[i].cyc), 128'(conv_input_din), 128'(tbl[i].din));
            start = tbl[i].start;
        end
        tick();
        start = 1'b0;

        // parameter capture
        check("shift_ch1", 128'(conv_shift_din[9:5]), 128'(5));
        check("bias_ch1", 128'(conv_bias_din[63:32]), 128'(32'h100));
        check("wgt_ch1", 128'(conv_weight_din[143:72]), 128'(w));
        check("shift_ch2", 128'(conv_shift_din[14:10]), 128'(31));
        check("bias_ch0", 128'(conv_bias_din[31:0]), 128'(32'hAAAA0001));

        while (cyc - c0 < 59) tick();
        check("c59_done", 128'({done, busy}), 128'(2'b01));
        tick();
        check("c60_done_err", 128'({done, err}), 128'(2'b10));
        tick();
        check("c61_busy", 128'({busy, done}), 0);
        check("tile1_done_cnt", 128'(done_cnt - d0), 1);
        check("tile1_err_cnt", 128'(err_cnt - e0), 0);
        check_tile(n0, NOUT);

        // back-to-back start right after done
        n0 = wa.size();
        start = 1'b1;
        c1 = cyc;
        tick();
        start = 1'b0;
        check("b2b_load", 128'({busy, param_rd_en, param_rd_addr}), 128'(4'b1100));
        wait_end(200);
        check("b2b_done_cycle", 128'(cyc - c1), 60);
        check("b2b_done", 128'({done, err}), 128'(2'b10));
        tick();
        check_tile(n0, NOUT);

        // timeout: dconv never signals end
        stub_end = 1'b0;
        d0 = done_cnt;
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        while (cyc - c0 < 41 + TO - 1) tick();
        check("to_before", 128'({err, busy}), 128'(2'b01));
        tick();
        check("to_err", 128'({done, err}), 128'(2'b01));
        tick();
        check("to_after", 128'({busy, err}), 0);
        check("to_no_done", 128'(done_cnt - d0), 0);
        stub_end = 1'b1;

        // output-count mismatch
        stub_nvld = NOUT - 1;
        n0 = wa.size();
        d0 = done_cnt;
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        wait_end(200);
        check("mm_err", 128'({done, err}), 128'(2'b01));
        check("mm_cycle", 128'(cyc - c0), 59);
        tick();
        check("mm_no_done", 128'(done_cnt - d0), 0);
        check("mm_writes", 128'(wa.size() - n0), 128'(NOUT - 1));
        stub_nvld = NOUT;

        // reset in the middle of STREAM
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        while (cyc - c0 < 25) tick();
        check("mid_fmap_addr", 128'(fmap_rd_addr), 128'(20));
        rst = 1'b1;
        tick();
        check("mr_busy_done_err", 128'({busy, done, err}), 0);
        check("mr_enables", 128'({param_rd_en, fmap_rd_en, conv_input_vld, out_wr_en}), 0);
        check("mr_conv_rst_n", 128'(conv_rst_n), 1);
        check("mr_addrs", 128'({param_rd_addr, fmap_rd_addr, out_wr_addr}), 0);
        check("mr_params", 128'({|conv_weight_din, |conv_bias_din, |conv_shift_din}), 0);
        rst = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        repeat (60) tick();
        check("mr_quiet", 128'((done_cnt - d0) + (err_cnt - e0)), 0);
        n0 = wa.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_end(200);
        check("mr_done", 128'({done, err}), 128'(2'b10));
        tick();
        check_tile(n0, NOUT);

        check("never_done_and_err", 128'(both_cnt), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
